// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//   Multi-cycle 32x32 multiply / 32/32 divide sequencer for the EX stage.
//   Each CALC cycle performs one add (multiply, shift-add) or one subtract
//   (divide, restoring). These go through the shared external ALU. The
//   result is returned as {hi,lo} in MIPS HI/LO style.
//
//   Optional feature macro: MULDIV_SIGNED_EN
//     defined   : op[1]=1 selects MULT/DIV. CALC works on operand magnitudes
//                 and a SIGN cycle fixes up the result signs afterwards.
//     undefined : op[1] is ignored. MULT/DIV behave as MULTU/DIVU.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous reset, active-high
//   start     in   1      request, accepted only in IDLE
//   op        in   2      00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   src_a     in   W      multiplicand / dividend
//   src_b     in   W      multiplier / divisor
//   busy      out  1      high in CALC and SIGN
//   done      out  1      one-cycle pulse, hi/lo valid
//   hi        out  W      product[63:32] / remainder
//   lo        out  W      product[31:0]  / quotient
//   alu_a     out  W      ALU dataA
//   alu_b     out  W      ALU dataB
//   alu_sig   out  3      ALU function select
//   alu_out   in   W      ALU result (combinational)
//   alu_zero  in   1      ALU zero flag (not used here)
//
// State table
//   state  | meaning
//   IDLE   | waiting for start; hi/lo hold the last result
//   CALC   | one ALU iteration per cycle, count 0..WIDTH-1
//   SIGN   | signed fix-up of product / quotient / remainder
//   DONE   | done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sig,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             div_q, div_d;       // 1: divide, 0: multiply
  logic             sgn_q, sgn_d;       // signed op, SIGN step required
  logic             neg_res_q, neg_res_d; // operand signs differ
  logic             neg_rem_q, neg_rem_d; // dividend was negative

  // The ALU zero flag is only consumed by the bench.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  // Operand sign handling at accept time. With the feature disabled the
  // negation paths are constant-folded away.
  logic             sgn_req;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign sgn_req = SIGNED_EN & op[1];
  assign a_neg   = sgn_req & src_a[WIDTH-1];
  assign b_neg   = sgn_req & src_b[WIDTH-1];
  assign a_mag   = a_neg ? (~src_a + WIDTH'(1)) : src_a;
  assign b_mag   = b_neg ? (~src_b + WIDTH'(1)) : src_b;

  // Restoring-division partial remainder: the remainder shifted left by one
  // with the next dividend bit. hi[31] is the 33rd bit of that shift, and
  // when set the subtraction always succeeds.
  logic [WIDTH-1:0] div_a;
  logic             div_ge;
  logic             mul_c;

  assign div_a  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign div_ge = hi_q[WIDTH-1] | (div_a >= b_q);
  // Carry out of hi + B: the sum wrapped iff it is below an addend.
  assign mul_c  = (alu_out < hi_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      div_q     <= 1'b0;
      sgn_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      b_q       <= b_d;
      div_q     <= div_d;
      sgn_q     <= sgn_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    div_d     = div_q;
    sgn_d     = sgn_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_sig   = ALU_ADD;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          div_d     = op[0];
          sgn_d     = sgn_req;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          b_d       = b_mag;
          hi_d      = '0;
          lo_d      = a_mag;
          count_d   = '0;
          if (op[0] && (src_b == '0)) begin
            // Divide by zero: fixed result, no iterations and no sign fix-up.
            hi_d    = src_a;
            lo_d    = '1;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        alu_b = b_q;
        if (div_q) begin
          alu_a   = div_a;
          alu_sig = ALU_SUB;
          if (div_ge) begin
            hi_d = alu_out;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = div_a;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          alu_a   = hi_q;
          alu_sig = ALU_ADD;
          if (lo_q[0]) begin
            hi_d = {mul_c, alu_out[WIDTH-1:1]};
            lo_d = {alu_out[0], lo_q[WIDTH-1:1]};
          end else begin
            hi_d = {1'b0, hi_q[WIDTH-1:1]};
            lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
          end
        end
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = sgn_q ? S_SIGN : S_DONE;
        end
      end

      S_SIGN: begin
        if (div_q) begin
          if (neg_res_q) lo_d = ~lo_q + WIDTH'(1);
          if (neg_rem_q) hi_d = ~hi_q + WIDTH'(1);
        end else if (neg_res_q) begin
          {hi_d, lo_d} = ~{hi_q, lo_q} + (2*WIDTH)'(1);
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q == S_CALC) || (state_q == S_SIGN);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_TB = 1'b1;
`else
  localparam bit SIGNED_TB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_sig;
  logic [31:0] alu_out;
  logic        alu_zero;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sig(alu_sig),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  // Shared 32-bit ALU model
  always_comb begin
    alu_out = 32'h0;
    case (alu_sig)
      3'b000: alu_out = alu_a & alu_b;
      3'b001: alu_out = alu_a | alu_b;
      3'b010: alu_out = alu_a + alu_b;
      3'b110: alu_out = alu_a - alu_b;
      3'b111: alu_out = {31'h0, $signed(alu_a) < $signed(alu_b)};
      default: alu_out = 32'h0;
    endcase
  end
  assign alu_zero = (alu_out == 32'h0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    int     sa, sb, q, r;
    longint p;
    bit     sgn;
    sgn = SIGNED_TB && o[1];
    sa = int'(a);
    sb = int'(b);
    if (o[0]) begin
      if (b == 32'h0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      return {a % b, a / b};
    end
    if (sgn) begin
      p = longint'(sa) * longint'(sb);
      return 64'(p);
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  // Runs one operation; with hold=1 start stays high (with junk operands)
  // for the whole operation and must be ignored.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit hold);
    int          cyc, busy_n, lat;
    logic [63:0] exp, got;
    lat = (o[0] && b == 32'h0) ? 1 : ((SIGNED_TB && o[1]) ? 34 : 33);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    exp_q.push_back(ref_res(o, a, b));
    cyc = 0; busy_n = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_n++;
      if (hold && !done) begin
        src_a = $urandom; src_b = $urandom; op = 2'($urandom_range(0, 3));
      end else begin
        start = 1'b0;
      end
      if (done || cyc > 60) break;
    end
    check({tag, " timeout"}, {63'h0, done}, 64'h1);
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " busy cycles"}, 64'(busy_n), 64'(lat - 1));
    if (exp_q.size() == 0) begin
      check({tag, " unexpected done"}, 64'h1, 64'h0);
    end else begin
      exp = exp_q.pop_front();
      got = {hi, lo};
      check({tag, " hi"}, {32'h0, got[63:32]}, {32'h0, exp[63:32]});
      check({tag, " lo"}, {32'h0, got[31:0]}, {32'h0, exp[31:0]});
      // Result holds and no further done while idle.
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check({tag, " no extra done"}, {63'h0, done}, 64'h0);
        check({tag, " hold"}, {hi, lo}, exp);
      end
      check({tag, " idle alu"}, {alu_a, alu_b}, 64'h0);
      check({tag, " idle sig"}, 64'(alu_sig), 64'h2);
    end
  endtask

  initial begin
    int n_done;
    rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    check("rst busy", {63'h0, busy}, 64'h0);
    check("rst done", {63'h0, done}, 64'h0);
    check("rst hilo", {hi, lo}, 64'h0);
    check("rst alu ab", {alu_a, alu_b}, 64'h0);
    check("rst alu sig", 64'(alu_sig), 64'h2);
    rst = 1'b0;

    do_op("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("divu 100/7", 2'b01, 32'd100, 32'd7, 1'b0);
    do_op("divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op("divu 5/0", 2'b01, 32'd5, 32'd0, 1'b0);
    do_op("held start", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    do_op("held start div", 2'b01, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);

    // Reset in the middle of CALC (count=10) aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 32'd77; src_b = 32'd99;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre-abort busy", {63'h0, busy}, 64'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", {63'h0, busy}, 64'h0);
    check("abort done", {63'h0, done}, 64'h0);
    check("abort hilo", {hi, lo}, 64'h0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort no done", 64'(n_done), 64'h0);
    do_op("multu 3*4", 2'b00, 32'd3, 32'd4, 1'b0);

    // Signed ops (behave unsigned without the feature).
    do_op("mult 3*4", 2'b10, 32'd3, 32'd4, 1'b0);
    do_op("mult -3*5", 2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0);
    do_op("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op("div min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op("div -9/0", 2'b11, 32'hFFFF_FFF7, 32'd0, 1'b0);
    do_op("div 9/-4", 2'b11, 32'd9, 32'hFFFF_FFFC, 1'b0);

    for (int i = 0; i < 8; i++) begin
      do_op("random", 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
    end

    check("scoreboard empty", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
